// File: rtl/dpr_bist_if.sv
// RAM-side bus between the BIST initiator and the 64x8 dual-port RAM.
// The write port is A, the read port is B, and q_b is the registered read data.
interface dpr_bist_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] addr_a;
    logic [DATA_WIDTH-1:0] data_a;
    logic                  we_a;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic [DATA_WIDTH-1:0] data_b;
    logic                  we_b;
    logic [DATA_WIDTH-1:0] q_b;

    modport master (
        output addr_a, data_a, we_a,
        output addr_b, data_b, we_b,
        input  q_b
    );

    modport slave (
        input  addr_a, data_a, we_a,
        input  addr_b, data_b, we_b,
        output q_b
    );
endinterface

// File: rtl/dpr_bist.sv
// BIST initiator for the dual-port RAM. It writes an address-dependent pattern,
// reads it back, repeats the sequence with the inverted pattern, and captures the first mismatch.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | RAM released, waiting for start
// S_WRITE | port A writes pat(cnt, p) to every location
// S_READ  | port B reads every location; the compare trails by one cycle
// S_FLUSH | no new read; the last address is compared here
// S_DONE  | one-cycle done pulse, then back to idle
module dpr_bist #(
    parameter int                  ADDR_WIDTH = 6,
    parameter int                  DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] SEED     = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_data,
    output logic                  fail_pass,
    dpr_bist_if.master            ram
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_FLUSH,
        S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] CNT_MAX = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] CNT_ONE = ADDR_WIDTH'(1);

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] cnt;
    logic                  p;
    logic                  err;
    logic                  cmp_vld;
    logic [ADDR_WIDTH-1:0] cmp_addr;

    logic [ADDR_WIDTH-1:0] addr_a;
    logic [DATA_WIDTH-1:0] data_a;
    logic                  we_a;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic                  cnt_last;
    logic                  mismatch;

    function automatic logic [DATA_WIDTH-1:0] pat(input logic [ADDR_WIDTH-1:0] a,
                                                  input logic pp);
        logic [DATA_WIDTH-1:0] ax;
        ax = DATA_WIDTH'(a);
        return (SEED ^ ax) ^ {DATA_WIDTH{pp}};
    endfunction

    assign cnt_last = (cnt == CNT_MAX);
    assign mismatch = cmp_vld && (ram.q_b != pat(cmp_addr, p));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // RAM-side outputs depend on state and cnt only, never on start or q_b.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        we_a      = 1'b0;
        addr_a    = '0;
        data_a    = '0;
        addr_b    = '0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                busy   = 1'b1;
                we_a   = 1'b1;
                addr_a = cnt;
                data_a = pat(cnt, p);
                if (cnt_last) begin
                    state_nxt = S_READ;
                end
            end
            S_READ: begin
                busy   = 1'b1;
                addr_b = cnt;
                if (cnt_last) begin
                    state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                busy      = 1'b1;
                state_nxt = p ? S_DONE : S_WRITE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            p         <= 1'b0;
            err       <= 1'b0;
            cmp_vld   <= 1'b0;
            cmp_addr  <= '0;
            pass      <= 1'b0;
            fail_addr <= '0;
            fail_data <= '0;
            fail_pass <= 1'b0;
        end else begin
            cmp_vld  <= (state == S_READ);
            cmp_addr <= cnt;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        cnt       <= '0;
                        p         <= 1'b0;
                        err       <= 1'b0;
                        pass      <= 1'b0;
                        fail_addr <= '0;
                        fail_data <= '0;
                        fail_pass <= 1'b0;
                    end
                end
                S_WRITE, S_READ: begin
                    // Wraps to 0 exactly on the cnt_last edge, which is also the phase change.
                    cnt <= cnt + CNT_ONE;
                end
                S_FLUSH: begin
                    cnt <= '0;
                    if (!p) begin
                        p <= 1'b1;
                    end else begin
                        // The final compare lands on this same edge, so it is folded in here
                        // to make pass valid in the done cycle.
                        pass <= !(err || mismatch);
                    end
                end
                default: begin
                end
            endcase

            if (mismatch) begin
                err <= 1'b1;
                if (!err) begin
                    fail_addr <= cmp_addr;
                    fail_data <= ram.q_b;
                    fail_pass <= p;
                end
            end
        end
    end

    assign ram.addr_a = addr_a;
    assign ram.data_a = data_a;
    assign ram.we_a   = we_a;
    assign ram.addr_b = addr_b;
    assign ram.data_b = '0;
    assign ram.we_b   = 1'b0;

endmodule

// File: tb/tb_dpr_bist.sv
// Directed bench for dpr_bist: a behavioural 64x8 RAM with a registered read port
// and q_b bit-flip fault injection, driven through a linear sequence of test steps.
module tb_dpr_bist;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       busy;
    logic       done;
    logic       pass;
    logic [5:0] fail_addr;
    logic [7:0] fail_data;
    logic       fail_pass;

    int n_vec = 0;
    int n_err = 0;

    dpr_bist_if #(.ADDR_WIDTH(6), .DATA_WIDTH(8)) bus ();

    dpr_bist #(.ADDR_WIDTH(6), .DATA_WIDTH(8), .SEED(8'hA5)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail_addr (fail_addr),
        .fail_data (fail_data),
        .fail_pass (fail_pass),
        .ram       (bus)
    );

    always #5 clk = ~clk;

    // RAM model. wr_cnt counts port-A writes since the last start, so 64 means
    // the pass-0 read phase is running and 128 the pass-1 read phase.
    logic [7:0] mem [64];
    logic [7:0] q_reg = 8'h00;
    logic [7:0] fmask = 8'h00;
    logic [7:0] wr_cnt = 8'h00;
    logic       wr_clr = 1'b0;
    logic       flt0_en = 1'b0;
    logic       flt1_en = 1'b0;

    always @(posedge clk) begin
        if (bus.we_a) mem[bus.addr_a] <= bus.data_a;
        q_reg <= mem[bus.addr_b];
        fmask <= 8'h00;
        if (flt0_en && !bus.we_a && bus.addr_b == 6'h05 && wr_cnt == 8'd64) fmask <= 8'h01;
        if (flt1_en && !bus.we_a && bus.addr_b == 6'h20 && wr_cnt == 8'd128) fmask <= 8'h81;
        if (wr_clr) wr_cnt <= 8'h00;
        else if (bus.we_a) wr_cnt <= wr_cnt + 8'd1;
    end

    assign bus.q_b = q_reg ^ fmask;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Pulses start and follows the whole run; restart_at > 0 re-pulses start at that busy cycle.
    task automatic run_test(input string tag, input int restart_at, input logic e_pass,
                            input logic [5:0] e_addr, input logic [7:0] e_data,
                            input logic e_fpass);
        int bc;
        @(negedge clk);
        start  = 1'b1;
        wr_clr = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        wr_clr = 1'b0;
        chk({tag, " busy_on_start"}, busy, 1);
        chk({tag, " pass_clr"}, pass, 0);
        chk({tag, " faddr_clr"}, fail_addr, 0);
        chk({tag, " fdata_clr"}, fail_data, 0);
        chk({tag, " fpass_clr"}, fail_pass, 0);
        bc = 0;
        while (busy === 1'b1 && bc < 1000) begin
            bc++;
            start = (bc == restart_at);
            if (bc == 1) begin
                chk({tag, " w0_we"}, bus.we_a, 1);
                chk({tag, " w0_data"}, bus.data_a, 8'hA5);
            end
            if (bc == 70) begin
                chk({tag, " r5_we"}, bus.we_a, 0);
                chk({tag, " r5_addr"}, bus.addr_b, 6'h05);
            end
            if (bc == 133) begin
                chk({tag, " w3p1_addr"}, bus.addr_a, 6'h03);
                chk({tag, " w3p1_data"}, bus.data_a, 8'h59);
            end
            chk({tag, " done_low_busy"}, done, 0);
            @(negedge clk);
        end
        start = 1'b0;
        chk({tag, " busy_cycles"}, bc, 258);
        chk({tag, " done"}, done, 1);
        chk({tag, " pass"}, pass, e_pass);
        chk({tag, " fail_addr"}, fail_addr, e_addr);
        chk({tag, " fail_data"}, fail_data, e_data);
        chk({tag, " fail_pass"}, fail_pass, e_fpass);
        @(negedge clk);
        chk({tag, " done_pulse"}, done, 0);
        chk({tag, " pass_hold"}, pass, e_pass);
        chk({tag, " busy_after"}, busy, 0);
    endtask

    initial begin
        int n;
        rst   = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst pass", pass, 0);
        chk("rst fail_addr", fail_addr, 0);
        chk("rst fail_data", fail_data, 0);
        chk("rst fail_pass", fail_pass, 0);
        chk("rst we_a", bus.we_a, 0);
        chk("rst addr_a", bus.addr_a, 0);
        chk("rst data_a", bus.data_a, 0);
        chk("rst addr_b", bus.addr_b, 0);
        chk("rst we_b", bus.we_b, 0);
        chk("rst data_b", bus.data_b, 0);

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle we_a", bus.we_a, 0);
        end

        run_test("clean", 0, 1'b1, 6'h00, 8'h00, 1'b0);
        chk("mem[3f]", mem[6'h3F], 8'h65);
        chk("mem[00]", mem[6'h00], 8'h5A);

        flt0_en = 1'b1;
        run_test("fault_p0", 0, 1'b0, 6'h05, 8'hA1, 1'b0);

        flt1_en = 1'b1;
        run_test("two_faults", 50, 1'b0, 6'h05, 8'hA1, 1'b0);

        flt0_en = 1'b0;
        run_test("fault_p1", 0, 1'b0, 6'h20, 8'hFB, 1'b1);

        flt1_en = 1'b0;
        run_test("rerun", 50, 1'b1, 6'h00, 8'h00, 1'b0);

        // Abort in WRITE at cnt 0x10.
        @(negedge clk);
        start  = 1'b1;
        wr_clr = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        wr_clr = 1'b0;
        n = 0;
        while (!(bus.we_a === 1'b1 && bus.addr_a === 6'h10) && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("abort reach cnt10", n < 200, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort busy", busy, 0);
        chk("abort we_a", bus.we_a, 0);
        chk("abort pass", pass, 0);
        @(negedge clk);
        chk("abort stays idle", bus.we_a, 0);

        run_test("after_abort", 0, 1'b1, 6'h00, 8'h00, 1'b0);

        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        chk("rst+start busy", busy, 0);
        @(negedge clk);
        chk("rst+start idle busy", busy, 0);
        chk("rst+start idle we_a", bus.we_a, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dpr_bist.md
# dpr_bist

Built-in self-test initiator for the 64x8 `dual_port_ram`. It drives the RAM's port-A write side and port-B read side, walks a two-pass address-dependent pattern through every location, and compares read-back data. It sits beside the RAM in the design: on `start` it takes ownership of both RAM ports, and it reports pass/fail plus the first failing location to the system.

## Interface
- `ADDR_WIDTH`, default 6: RAM address width. DEPTH = 2**ADDR_WIDTH.
- `DATA_WIDTH`, default 8: RAM data width.
- `SEED`, default 8'hA5: base pattern, `DATA_WIDTH` bits wide.
- Clocking: one clock; reset is synchronous and active-high.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous active-high reset.
- `start`  in  1  begin test. Sampled only in IDLE.
- `busy`  out  1  high while the test owns the RAM.
- `done`  out  1  one-cycle pulse when the test completes.
- `pass`  out  1  result, valid from `done` until the next `start` or `rst`.
- `fail_addr`  out  ADDR_WIDTH  address of the first mismatch.
- `fail_data`  out  DATA_WIDTH  data read at the first mismatch.
- `fail_pass`  out  1  pass index (0 or 1) of the first mismatch.
- `addr_a`  out  ADDR_WIDTH  RAM port-A address.
- `data_a`  out  DATA_WIDTH  RAM port-A write data.
- `we_a`  out  1  RAM port-A write enable.
- `addr_b`  out  ADDR_WIDTH  RAM port-B address.
- `data_b`  out  DATA_WIDTH  RAM port-B write data. Constant 0.
- `we_b`  out  1  RAM port-B write enable. Constant 0.
- `q_b`  in  DATA_WIDTH  RAM port-B read data.

## Operation
- **Expected data:** `exp(a, p) = (SEED ^ zext/trunc(a to DATA_WIDTH)) ^ {DATA_WIDTH{p}}`. Pass 0 uses the true pattern; pass 1 uses its inverse.
- **FSM states:** IDLE, WRITE, READ, FLUSH, DONE. Internal registers are `cnt` (ADDR_WIDTH bits), `p` (pass index), `err` (sticky), and `cmp_vld`/`cmp_addr` (compare pipeline).
- **IDLE:** `busy` = 0 and all RAM enables are 0.
  - If `start` = 1, go to WRITE with `cnt` = 0 and `p` = 0.
  - On entry from IDLE, clear `err`, `pass`, `fail_addr`, `fail_data` and `fail_pass`.
- **WRITE:** drive `we_a` = 1, `addr_a` = `cnt`, `data_a` = `exp(cnt, p)`.
  - `cnt` increments each cycle.
  - At `cnt` = DEPTH-1, go to READ with `cnt` = 0.
- **READ:** drive `addr_b` = `cnt`; `cnt` increments each cycle.
  - Set `cmp_vld` = 1 and `cmp_addr` = `cnt` for the next cycle.
  - At `cnt` = DEPTH-1, go to FLUSH.
- **FLUSH:** one cycle with no new read, so the last address can be compared.
  - If `p` = 0, go to WRITE with `p` = 1 and `cnt` = 0.
  - Otherwise go to DONE.
- **Compare:** in any cycle with `cmp_vld` = 1, check `q_b` against `exp(cmp_addr, p)`.
  - On mismatch with `err` = 0: set `err`, and capture `fail_addr` = `cmp_addr`, `fail_data` = `q_b`, `fail_pass` = `p`.
  - Later mismatches do not overwrite the capture, and the test runs to completion.
- **DONE:** one cycle with `done` = 1 and `busy` = 0; `pass` is loaded with `!err`. Then go to IDLE.
- **RAM-side outputs:** decoded from registered state and `cnt` only; there is no combinational path from `start` or `q_b`. Outside their active states, `we_a` = 0 and addresses/data are 0.
- **`start` handling:** `start` while not in IDLE is ignored. `start` held high re-triggers from IDLE after DONE.
- **Reset values:** state = IDLE; `busy`, `done`, `pass`, `fail_*`, `we_a`, `addr_a`, `data_a`, `addr_b` all 0.
- **Reset priority:** `rst` mid-test aborts immediately, and no further writes occur after that edge. `rst` together with `start` resolves as reset.

## Timing
- **RAM read latency:** `q_b` is registered in the RAM. It reflects `mem[addr_b]` in the cycle after the edge that sampled `addr_b`.
- **Compare timing:** the compare for address n happens in the cycle after `addr_b` = n and is registered at the end of that cycle.
- **Start:** `start` is sampled at edge k; WRITE is active from cycle k+1 with `busy` = 1.
- **Busy duration:** `busy` stays high for 2 × (2 × DEPTH + 1) cycles, which is 258 for DEPTH = 64.
- **Done:** `done` pulses for exactly one cycle immediately after, and `busy` = 0 in that cycle.
- **Write/read order:** port-A writes and port-B reads never overlap, so RAM read-during-write behaviour is irrelevant.
- **Address wrap:** `cnt` wraps from DEPTH-1 to 0 only on a state transition, never inside a phase.

## Test plan
- **Reset values:** assert `rst` for 2 cycles → all outputs 0 and `busy` = 0. Hold `start` = 0 for 10 cycles → `we_a` stays 0.
- **Clean run (default SEED):** pulse `start` → `busy` high for 258 cycles, then `done` for 1 cycle with `pass` = 1. RAM content then has `mem[0x3F]` = ~(0xA5 ^ 0x3F) = 0x65 and `mem[0x00]` = 0x5A.
- **Single fault, pass 0:** bench flips bit 0 of `q_b` when returning address 0x05 in pass 0 → `pass` = 0, `fail_addr` = 0x05, `fail_data` = 0xA1, `fail_pass` = 0.
- **Two faults:** flip `q_b` bits at address 0x05 in pass 0 and at address 0x20 in pass 1 → capture still shows 0x05 / pass 0. `done` arrives at the normal 258-cycle point.
- **Start while busy, then rerun:** pulse `start` again at busy cycle 50 → no effect on timing. After a failing run, a new `start` clears `pass`/`fail_*` on entry, and a clean rerun gives `pass` = 1.
- **Reset mid-test:** assert `rst` during WRITE at `cnt` = 0x10 → next cycle `busy` = 0, `we_a` = 0, `pass` = 0. A subsequent `start` completes a full clean run; `rst` and `start` in the same cycle leaves the block in IDLE.
